// File: rtl/ky32_irq_pkg.sv
// Shared widths and FSM encodings for the KY32 interrupt controller.
package ky32_irq_pkg;
    localparam int NSRC  = 8;
    localparam int VEC_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;
endpackage

// File: rtl/KY32_encoder8x3.sv
// 8->3 priority encoder, bit 7 highest; g flags a valid winner when enabled.
// Purely combinational, zero latency.
module KY32_encoder8x3 (
    input  logic [7:0] d,
    input  logic       ena,
    output logic [2:0] n,
    output logic       g
);
    always_comb begin
        n = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) n = 3'(i);
        end
        g = ena & (|d);
    end
endmodule

// File: rtl/ky32_irq_sync.sv
// Multi-flop synchroniser for the raw IRQ lines, cleared by synchronous reset.
// Latency: STAGES clock edges from din to dout.
module ky32_irq_sync
    import ky32_irq_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] din,
    output logic [NSRC-1:0] dout
);
    logic [STAGES-1:0][NSRC-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];
endmodule

// File: rtl/ky32_irq_ctrl.sv
// Eight-source interrupt controller: sync, edge/level latch, mask, encode, req/ack/eoi handshake.
// Latency: irq_in rise to irq_req is SYNC_STAGES+2 edges; one source in service at a time.
module ky32_irq_ctrl
    import ky32_irq_pkg::*;
#(
    parameter int              SYNC_STAGES = 2,
    parameter logic [NSRC-1:0] EDGE_MASK   = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  irq_in,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_wd,
    output logic [NSRC-1:0]  mask_q,
    output logic [NSRC-1:0]  pend_q,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             irq_eoi
);
    logic [NSRC-1:0]  s;
    logic [NSRC-1:0]  prev;
    logic [NSRC-1:0]  rise;
    logic [NSRC-1:0]  clr;
    logic [NSRC-1:0]  pend_d;
    logic [NSRC-1:0]  masked;
    logic [VEC_W-1:0] vec_r;
    logic [VEC_W-1:0] vec_d;
    logic [VEC_W-1:0] enc_n;
    logic             enc_g;
    state_t           state;
    state_t           state_d;

    ky32_irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (irq_in),
        .dout (s)
    );

    assign rise   = s & ~prev;
    assign masked = pend_q & mask_q;

    // Encoder only arbitrates in IDLE so the vector cannot change under the core.
    KY32_encoder8x3 u_enc (
        .d   (masked),
        .ena (state == ST_IDLE),
        .n   (enc_n),
        .g   (enc_g)
    );

    always_comb begin
        state_d = state;
        vec_d   = vec_r;
        clr     = '0;
        case (state)
            ST_IDLE: begin
                if (enc_g) begin
                    state_d = ST_REQ;
                    vec_d   = enc_n;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d    = ST_SVC;
                    clr[vec_r] = EDGE_MASK[vec_r];
                end else if (!masked[vec_r]) begin
                    // Request withdrawn: level dropped or source masked before ack.
                    state_d = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (irq_eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge bits hold until acked (a coincident new edge wins); level bits track s.
    assign pend_d = (EDGE_MASK & (rise | (pend_q & ~clr))) | (~EDGE_MASK & s);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev   <= '0;
            pend_q <= '0;
            mask_q <= '0;
            state  <= ST_IDLE;
            vec_r  <= '0;
        end else begin
            prev   <= s;
            pend_q <= pend_d;
            if (mask_we) mask_q <= mask_wd;
            state  <= state_d;
            vec_r  <= vec_d;
        end
    end

    assign irq_req = (state == ST_REQ);
    assign irq_vec = vec_r;
endmodule

// File: tb/tb_ky32_irq_ctrl.sv
module tb_ky32_irq_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wd;
    logic [7:0] mask_q;
    logic [7:0] pend_q;
    logic       irq_req;
    logic [2:0] irq_vec;
    logic       irq_ack;
    logic       irq_eoi;

    int checks = 0;
    int fails  = 0;

    // Source 2 is level-triggered, every other source edge-triggered.
    ky32_irq_ctrl #(.SYNC_STAGES(2), .EDGE_MASK(8'hFB)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .mask_we (mask_we),
        .mask_wd (mask_wd),
        .mask_q  (mask_q),
        .pend_q  (pend_q),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack),
        .irq_eoi (irq_eoi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string name, input logic exp_req, input logic [2:0] exp_vec, input logic use_vec);
        checks++;
        if (irq_req !== exp_req || (use_vec && irq_vec !== exp_vec)) begin
            fails++;
            $display("FAIL %s: irq_req=%b irq_vec=%0d, expected irq_req=%b irq_vec=%0d", name, irq_req, irq_vec, exp_req, exp_vec);
        end
    endtask

    task automatic chk_pend(input string name, input logic [7:0] exp);
        checks++;
        if (pend_q !== exp) begin
            fails++;
            $display("FAIL %s: pend_q=%h, expected %h", name, pend_q, exp);
        end
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we = 1'b1; mask_wd = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic ack_then_eoi();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; mask_we = 0; mask_wd = '0; irq_ack = 0; irq_eoi = 0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (mask_q !== 8'h00 || pend_q !== 8'h00 || irq_req !== 1'b0 || irq_vec !== 3'd0) begin
            fails++;
            $display("FAIL reset: mask=%h pend=%h req=%b vec=%0d, expected all 0", mask_q, pend_q, irq_req, irq_vec);
        end
        write_mask(8'hFF);
        checks++;
        if (mask_q !== 8'hFF) begin
            fails++;
            $display("FAIL mask_write: mask_q=%h, expected ff", mask_q);
        end
    endtask

    task automatic test_single_edge();
        irq_in = 8'h08; tick();          // edge 1
        irq_in = 8'h00; tick();          // edge 2
        chk_pend("single_pend_e2", 8'h00);
        tick();                          // edge 3
        chk_pend("single_pend_e3", 8'h08);
        chk_req("single_req_e3", 1'b0, 3'd0, 1'b0);
        tick();                          // edge 4
        chk_req("single_req_e4", 1'b1, 3'd3, 1'b1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk_pend("single_ack_clear", 8'h00);
        chk_req("single_svc", 1'b0, 3'd3, 1'b1);
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        tick(); tick();
        chk_req("single_after_eoi", 1'b0, 3'd3, 1'b1);
    endtask

    task automatic test_set_wins();
        irq_in = 8'h08; tick();          // edge 1
        irq_in = 8'h00; tick();          // edge 2
        irq_in = 8'h08; tick();          // edge 3: first set lands
        irq_in = 8'h00; tick();          // edge 4: request up
        chk_req("setwin_req", 1'b1, 3'd3, 1'b1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;   // edge 5: set and clear coincide
        chk_pend("setwin_pend", 8'h08);
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        tick();
        chk_req("setwin_rerequest", 1'b1, 3'd3, 1'b1);
        ack_then_eoi();
        chk_pend("setwin_drained", 8'h00);
    endtask

    task automatic test_priority();
        irq_in = 8'h41; tick();
        irq_in = 8'h00; tick(); tick();
        chk_pend("prio_pend", 8'h41);
        tick();
        chk_req("prio_first", 1'b1, 3'd6, 1'b1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk_pend("prio_after_ack", 8'h01);
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        chk_req("prio_eoi_idle", 1'b0, 3'd6, 1'b1);
        tick();
        chk_req("prio_second", 1'b1, 3'd0, 1'b1);
        ack_then_eoi();
        chk_pend("prio_drained", 8'h00);
    endtask

    task automatic test_level_withdraw();
        irq_in = 8'h04; tick(); tick(); tick();
        chk_pend("level_pend", 8'h04);
        tick();
        chk_req("level_req", 1'b1, 3'd2, 1'b1);
        irq_in = 8'h00; tick(); tick();
        chk_req("level_req_holds", 1'b1, 3'd2, 1'b1);
        tick();
        chk_pend("level_dropped", 8'h00);
        chk_req("level_req_still", 1'b1, 3'd2, 1'b1);
        tick();
        chk_req("level_withdrawn", 1'b0, 3'd2, 1'b1);
        tick(); tick();
        chk_req("level_stays_idle", 1'b0, 3'd2, 1'b1);
    endtask

    task automatic test_mask();
        write_mask(8'h00);
        irq_in = 8'h20; tick();
        irq_in = 8'h00; tick(); tick();
        chk_pend("mask_pend", 8'h20);
        tick(); tick();
        chk_req("mask_blocked", 1'b0, 3'd0, 1'b0);
        mask_we = 1'b1; mask_wd = 8'h20; tick(); mask_we = 1'b0;
        chk_req("mask_write_edge", 1'b0, 3'd0, 1'b0);
        tick();
        chk_req("mask_unblocked", 1'b1, 3'd5, 1'b1);
        ack_then_eoi();
        write_mask(8'hFF);
    endtask

    task automatic test_back_to_back();
        irq_in = 8'h02; tick();
        irq_in = 8'h00; tick(); tick(); tick();
        chk_req("svc_src1_req", 1'b1, 3'd1, 1'b1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_in = 8'h80; tick();
        irq_in = 8'h00; tick(); tick();
        chk_pend("svc_new_pend", 8'h80);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick();
        chk_req("svc_ack_ignored", 1'b0, 3'd1, 1'b1);
        chk_pend("svc_pend_kept", 8'h80);
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        chk_req("svc_eoi_idle", 1'b0, 3'd1, 1'b1);
        tick();
        chk_req("svc_next_vec", 1'b1, 3'd7, 1'b1);
        ack_then_eoi();
    endtask

    task automatic test_reset_in_service();
        irq_in = 8'h11; tick();
        irq_in = 8'h00; tick(); tick(); tick();
        chk_req("rst_svc_req", 1'b1, 3'd4, 1'b1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk_pend("rst_svc_pend", 8'h01);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (mask_q !== 8'h00 || pend_q !== 8'h00 || irq_req !== 1'b0 || irq_vec !== 3'd0) begin
            fails++;
            $display("FAIL reset_in_svc: mask=%h pend=%h req=%b vec=%0d, expected all 0", mask_q, pend_q, irq_req, irq_vec);
        end
        write_mask(8'hFF);
        tick(); tick(); tick();
        chk_req("rst_no_revival", 1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_set_wins();
        test_priority();
        test_level_withdraw();
        test_mask();
        test_back_to_back();
        test_reset_in_service();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
